// File: rtl/seqgen.sv
// seqgen: serial pattern transmitter.
// On an accepted start it latches a W-bit pattern, a copy count and an idle-gap
// length, then shifts the pattern out MSB first on x, one bit per clock. The
// pattern is sent rep times, with gap idle cycles between consecutive copies.
// All outputs are registered.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous reset, active-high
//   start   in   1   request, sampled only in IDLE
//   pat_in  in   W   pattern, latched on accepted start
//   rep_in  in   CW  copy count, latched on accepted start (0 = no data)
//   gap_in  in   GW  idle cycles between copies, latched on accepted start
//   x       out  1   serial data, 0 whenever x_vld=0
//   x_vld   out  1   x carries a pattern bit
//   x_last  out  1   x carries bit 0 of a copy
//   busy    out  1   request in progress (SEND or GAP)
//   done    out  1   one-cycle pulse after the request completes
//
// state | meaning
// IDLE  | waiting for start
// SEND  | driving pattern bit idx of the current copy
// GAP   | idle cycles between two copies
// DONE  | request finished, returns to IDLE on the next edge
module seqgen #(
   parameter int W  = 5,
   parameter int CW = 4,
   parameter int GW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  pat_in,
   input  logic [CW-1:0] rep_in,
   input  logic [GW-1:0] gap_in,
   output logic          x,
   output logic          x_vld,
   output logic          x_last,
   output logic          busy,
   output logic          done
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t        state, state_n;
   logic [W-1:0]  pat, pat_n;
   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] rem, rem_n;
   logic [GW-1:0] gap, gap_n;
   logic [GW-1:0] gcnt, gcnt_n;

   logic x_n, x_vld_n, x_last_n, busy_n, done_n;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pat    <= '0;
         idx    <= '0;
         rem    <= '0;
         gap    <= '0;
         gcnt   <= '0;
         x      <= 1'b0;
         x_vld  <= 1'b0;
         x_last <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         pat    <= pat_n;
         idx    <= idx_n;
         rem    <= rem_n;
         gap    <= gap_n;
         gcnt   <= gcnt_n;
         x      <= x_n;
         x_vld  <= x_vld_n;
         x_last <= x_last_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      pat_n   = pat;
      idx_n   = idx;
      rem_n   = rem;
      gap_n   = gap;
      gcnt_n  = gcnt;
      case (state)
         IDLE: begin
            if (start) begin
               pat_n   = pat_in;
               rem_n   = rep_in;
               gap_n   = gap_in;
               idx_n   = IDX_TOP;
               state_n = (rep_in == '0) ? DONE : SEND;
            end
         end
         SEND: begin
            if (idx == '0) begin
               // rem counts the copy currently on the wire, so it is never 0 here
               rem_n = rem - 1'b1;
               if (rem == CW'(1)) begin
                  state_n = DONE;
               end else if (gap == '0) begin
                  idx_n = IDX_TOP;
               end else begin
                  state_n = GAP;
                  gcnt_n  = gap - 1'b1;
               end
            end else begin
               idx_n = idx - 1'b1;
            end
         end
         GAP: begin
            if (gcnt == '0) begin
               state_n = SEND;
               idx_n   = IDX_TOP;
            end else begin
               gcnt_n = gcnt - 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output logic: values the output registers take at the coming edge
   always_comb begin
      x_vld_n  = (state_n == SEND);
      x_n      = x_vld_n & pat_n[idx_n];
      x_last_n = x_vld_n & (idx_n == '0);
      busy_n   = (state_n == SEND) || (state_n == GAP);
      // After the last copy the pulse coincides with entering DONE. A zero-copy
      // request has no data to finish, so its pulse comes one edge later, on
      // the way out of DONE.
      done_n   = ((state_n == DONE) && (state != IDLE)) ||
                 ((state == DONE) && !done);
   end

endmodule

// File: tb/tb_seqgen.sv
module tb_seqgen;

   localparam int W  = 5;
   localparam int CW = 4;
   localparam int GW = 3;
   localparam logic [W-1:0] TARGET = 5'b10110;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  pat_in;
   logic [CW-1:0] rep_in;
   logic [GW-1:0] gap_in;
   logic          x, x_vld, x_last, busy, done;

   seqgen #(.W(W), .CW(CW), .GW(GW)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .pat_in (pat_in),
      .rep_in (rep_in),
      .gap_in (gap_in),
      .x      (x),
      .x_vld  (x_vld),
      .x_last (x_last),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // observed outputs as {x, x_vld, x_last, busy, done}
   logic [4:0] obs;
   assign obs = {x, x_vld, x_last, busy, done};

   int n_chk  = 0;
   int n_pass = 0;

   logic [4:0] exp_q[$];

   typedef struct {
      logic [W-1:0] pat;
      int           rep;
      int           gap;
      int           done_at;
      int           nlast;
      int           nz;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %b, expected %b (x,vld,last,busy,done)", name, act, expv);
   endtask

   task automatic chk_int(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
   endtask

   // Reference: cycle-by-cycle outputs from the accepting edge onward.
   function automatic void build_exp(input logic [W-1:0] p, input int rep, input int gap);
      exp_q.delete();
      if (rep == 0) begin
         exp_q.push_back(5'b00000);
         exp_q.push_back(5'b00001);
      end else begin
         for (int c = 0; c < rep; c++) begin
            for (int b = W - 1; b >= 0; b--)
               exp_q.push_back({p[b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (c < rep - 1)
               for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
         end
         exp_q.push_back(5'b00001);
      end
   endfunction

   // Issue one request (caller is just past a rising edge) and check every cycle.
   task automatic do_req(input logic [W-1:0] p, input int rep, input int gap, input bit noise,
                         output int done_at, output int nlast, output int nz);
      logic [W-1:0] win;
      int nsh;
      build_exp(p, rep, gap);
      pat_in  = p;
      rep_in  = CW'(rep);
      gap_in  = GW'(gap);
      start   = 1'b1;
      win     = '0;
      nsh     = 0;
      done_at = -1;
      nlast   = 0;
      nz      = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clk);
         #1;
         chk("stream", obs, exp_q[k]);
         if (done && done_at < 0) done_at = k;
         nlast += int'(x_last);
         win = {win[W-2:0], x};
         nsh++;
         if (nsh >= W && win == TARGET) nz++;
         start = (noise && k < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            pat_in = W'($urandom_range(0, 31));
            rep_in = CW'($urandom_range(0, 15));
            gap_in = GW'($urandom_range(0, 7));
         end
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after", obs, 5'b00000);
   endtask

   initial begin
      int da, nl, nzz;

      vecs[0] = '{5'b10110,  1, 0,   5,  1,  1};
      vecs[1] = '{5'b10110,  3, 2,  19,  3,  3};
      vecs[2] = '{5'b10110,  0, 3,   1,  0,  0};
      vecs[3] = '{5'b10110,  2, 0,  10,  2,  2};
      vecs[4] = '{5'b10111,  2, 0,  10,  2,  0};
      vecs[5] = '{5'b10110, 15, 7, 173, 15, 15};
      vecs[6] = '{5'b01001,  1, 7,   5,  1,  0};
      vecs[7] = '{5'b11111,  4, 1,  23,  4,  0};

      // reset held with clock running; start during reset must be ignored
      rst    = 1'b1;
      start  = 1'b1;
      pat_in = 5'b10110;
      rep_in = 4'd1;
      gap_in = 3'd0;
      #7;
      chk("reset_hold", obs, 5'b00000);
      #5 start = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("reset_release", obs, 5'b00000);
      @(posedge clk);
      #1;
      chk("reset_idle", obs, 5'b00000);

      // table of requests with hand-derived timing and loopback detector counts
      foreach (vecs[i]) begin
         do_req(vecs[i].pat, vecs[i].rep, vecs[i].gap, 1'b0, da, nl, nzz);
         chk_int($sformatf("done_at[%0d]", i), da, vecs[i].done_at);
         chk_int($sformatf("nlast[%0d]", i), nl, vecs[i].nlast);
         chk_int($sformatf("detect[%0d]", i), nzz, vecs[i].nz);
      end

      // start during a copy ignored, then reset mid-copy abandons the request
      build_exp(5'b10110, 2, 0);
      pat_in = 5'b10110;
      rep_in = 4'd2;
      gap_in = 3'd0;
      start  = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(posedge clk);
         #1;
         chk("abort_stream", obs, exp_q[k]);
         start  = (k == 1);
         pat_in = W'($urandom_range(0, 31));
      end
      #2 rst = 1'b1;
      #1;
      chk("abort_rst_async", obs, 5'b00000);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", obs, 5'b00000);
      end
      do_req(5'b10110, 1, 0, 1'b0, da, nl, nzz);
      chk_int("abort_restart_done_at", da, 5);

      // randomized requests with noise on inputs while busy
      for (int i = 0; i < 30; i++) begin
         int r;
         r = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 5);
         do_req(W'($urandom_range(0, 31)), r, $urandom_range(0, 7), 1'b1, da, nl, nzz);
         chk_int("rand_done_at", da, (r == 0) ? 1 : exp_q.size() - 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
